// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types for the UART transmit scheduler: the frame-format
//               record driven onto the TX state machine and the scheduler
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Width of one requester's format field on Req_Fmt.
    localparam int c_FMT_W = 5;

    // Frame format: {Len, NumStop, ParEn, Par[1:0]}.
    typedef struct packed {
        logic       len;
        logic       num_stop;
        logic       par_en;
        logic [1:0] par;
    } uart_fmt_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        XFER  = 2'd3
    } tx_sched_st_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches the request vector
//               from the pointer position upward with wrap-around and returns
//               the first requester found.
// Ports       : i_req [N]   request vector
//               i_ptr [IW]  search start position
//               o_gnt [N]   one-hot grant, 0 when no request
//               o_idx [IW]  index of the granted requester
//               o_any       at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                    i_req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_ptr,
    output logic [N-1:0]                    o_gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_idx,
    output logic                            o_any
);

    localparam int c_IW = (N > 1) ? $clog2(N) : 1;

    logic [c_IW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = c_IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Shares one UART transmitter between NUM_REQ byte-stream
//               requesters. Round-robin arbitration with a per-message lock,
//               bursts limited to MAX_BURST bytes, granted bytes pushed into
//               the TX FIFO. A frame-format change is only applied once the
//               FIFO is empty and the TX state machine is idle, so no
//               character goes out with a mixed format.
// Ports       : Clk, Rst            clock, synchronous active-high reset
//               Req_Vld/Data/Last   per-requester byte stream
//               Req_Fmt             per-requester {Len,NumStop,ParEn,Par}
//               Req_Rdy             per-requester accept
//               TF_FF/TF_EF/TxIdle  TX FIFO full/empty, TX state machine idle
//               TF_WE/TF_DI         TX FIFO write strobe and data
//               Len/NumStop/ParEn/Par  applied frame format
//               Grant/Busy          current owner (one-hot), not arbitrating
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [NUM_REQ-1:0]     Req_Vld,
    input  logic [8*NUM_REQ-1:0]   Req_Data,
    input  logic [NUM_REQ-1:0]     Req_Last,
    input  logic [5*NUM_REQ-1:0]   Req_Fmt,
    output logic [NUM_REQ-1:0]     Req_Rdy,
    input  logic                   TF_FF,
    input  logic                   TF_EF,
    input  logic                   TxIdle,
    output logic                   TF_WE,
    output logic [7:0]             TF_DI,
    output logic                   Len,
    output logic                   NumStop,
    output logic                   ParEn,
    output logic [1:0]             Par,
    output logic [NUM_REQ-1:0]     Grant,
    output logic                   Busy
);

    localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    tx_sched_st_t     r_state, w_next;
    uart_fmt_t        r_fmt;
    logic [c_IW-1:0]  r_ptr;
    logic [c_IW-1:0]  r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [7:0]       r_cnt;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [c_IW-1:0]  w_arb_idx;
    logic             w_arb_any;
    uart_fmt_t        w_arb_fmt;
    uart_fmt_t        w_own_fmt;
    logic             w_own_vld;
    logic             w_own_last;
    logic [7:0]       w_own_data;
    logic             w_accept;
    logic [7:0]       w_cnt_inc;
    logic             w_exit;
    logic [c_IW-1:0]  w_ptr_next;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_req (Req_Vld),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_arb_fmt  = uart_fmt_t'(Req_Fmt[c_FMT_W*int'(w_arb_idx) +: c_FMT_W]);
    assign w_own_fmt  = uart_fmt_t'(Req_Fmt[c_FMT_W*int'(r_owner) +: c_FMT_W]);
    assign w_own_vld  = Req_Vld[r_owner];
    assign w_own_last = Req_Last[r_owner];
    assign w_own_data = Req_Data[8*int'(r_owner) +: 8];

    // Reset gates the accept so a byte presented in the reset cycle is dropped.
    assign w_accept   = (r_state == XFER) && w_own_vld && !TF_FF && !Rst;
    assign w_cnt_inc  = r_cnt + 8'd1;
    // Last and burst limit on the same byte still produce a single exit.
    assign w_exit     = w_accept && (w_own_last || (w_cnt_inc == 8'(MAX_BURST)));
    assign w_ptr_next = (r_owner == c_IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        Req_Rdy = '0;
        TF_WE   = 1'b0;
        TF_DI   = 8'h00;
        case (r_state)
            ARB: begin
                if (w_arb_any) begin
                    w_next = (w_arb_fmt == r_fmt) ? XFER : DRAIN;
                end
            end
            DRAIN: begin
                if (TF_EF && TxIdle) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = XFER;
            end
            XFER: begin
                // Owner dropping Req_Vld keeps the grant: message lock.
                Req_Rdy[r_owner] = !TF_FF && !Rst;
                TF_WE            = w_accept;
                TF_DI            = w_accept ? w_own_data : 8'h00;
                if (w_exit) begin
                    w_next = ARB;
                end
            end
            default: begin
                w_next = ARB;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_fmt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_arb_any) begin
                        r_grant <= w_arb_gnt;
                        r_owner <= w_arb_idx;
                    end
                end
                LOAD: begin
                    r_fmt <= w_own_fmt;
                end
                XFER: begin
                    if (w_exit) begin
                        r_ptr   <= w_ptr_next;
                        r_grant <= '0;
                        r_cnt   <= 8'd0;
                    end else if (w_accept) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Grant   = r_grant;
    assign Busy    = (r_state != ARB);
    assign Len     = r_fmt.len;
    assign NumStop = r_fmt.num_stop;
    assign ParEn   = r_fmt.par_en;
    assign Par     = r_fmt.par;

endmodule : uart_tx_sched
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Randomized self-checking bench for uart_tx_sched. Stimulus
//               queues per-requester messages; a monitor checks writes,
//               arbitration order, burst limits and format gating against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [4:0] fmt;
        logic [7:0] data;
        logic       last;
    } item_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld, req_last, req_rdy, grant;
    logic [8*N-1:0] req_data;
    logic [5*N-1:0] req_fmt;
    logic           tf_ff, tf_ef, tx_idle, tf_we, len, num_stop, par_en, busy;
    logic [7:0]     tf_di;
    logic [1:0]     par;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .Clk(clk), .Rst(rst), .Req_Vld(req_vld), .Req_Data(req_data),
        .Req_Last(req_last), .Req_Fmt(req_fmt), .Req_Rdy(req_rdy),
        .TF_FF(tf_ff), .TF_EF(tf_ef), .TxIdle(tx_idle), .TF_WE(tf_we),
        .TF_DI(tf_di), .Len(len), .NumStop(num_stop), .ParEn(par_en),
        .Par(par), .Grant(grant), .Busy(busy)
    );

    int    n_vec = 0;
    int    n_err = 0;
    item_t drv_q[N][$];
    item_t exp_q[N][$];

    logic  gen_en = 1'b0, wh_en = 1'b0, rnd_tf = 1'b0;
    logic  f_ff = 1'b0, f_ef = 1'b1, f_idle = 1'b1;
    logic [4:0] fmts [3] = '{5'b00000, 5'b11011, 5'b00101};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int r = 0; r < N; r++) s += exp_q[r].size();
        return s;
    endfunction

    task automatic add_msg(input int r, input logic [4:0] f, input int n, input logic [7:0] base);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.fmt  = f;
            it.data = base + 8'(i);
            it.last = (i == n - 1);
            drv_q[r].push_back(it);
            exp_q[r].push_back(it);
        end
    endtask

    task automatic apply();
        for (int r = 0; r < N; r++) begin
            if (drv_q[r].size() > 0) begin
                req_vld[r]          = !(wh_en && $urandom_range(3) == 0);
                req_data[8*r +: 8]  = drv_q[r][0].data;
                req_last[r]         = drv_q[r][0].last;
                req_fmt[5*r +: 5]   = drv_q[r][0].fmt;
            end else begin
                req_vld[r]  = 1'b0;
                req_last[r] = 1'b0;
            end
        end
        if (rnd_tf) begin
            tf_ff   = ($urandom_range(3) == 0);
            tf_ef   = ($urandom_range(9) < 7);
            tx_idle = ($urandom_range(9) < 7);
        end else begin
            tf_ff   = f_ff;
            tf_ef   = f_ef;
            tx_idle = f_idle;
        end
    endtask

    // One clock: note accepts before the edge, retire them, drive new inputs.
    task automatic cycle();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_vld & req_rdy;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) if (acc[r]) void'(drv_q[r].pop_front());
        if (gen_en) begin
            for (int r = 0; r < N; r++)
                if (drv_q[r].size() == 0 && $urandom_range(7) == 0)
                    add_msg(r, fmts[$urandom_range(2)], $urandom_range(1, 7), 8'($urandom));
        end
        apply();
    endtask

    // ------------------------------------------------------------ monitor
    initial begin : monitor
        logic [N-1:0] p_grant, p_vld, exp_g;
        logic         p_busy, p_rst, ef1, ef2, t_last;
        logic [4:0]   p_fmt, cur_fmt;
        int           m_ptr, t_cnt, t_owner, j_exp;
        item_t        e;
        p_grant = '0; p_vld = '0; p_busy = 1'b0; p_rst = 1'b1;
        ef1 = 1'b0; ef2 = 1'b0; t_last = 1'b0; p_fmt = '0;
        m_ptr = 0; t_cnt = 0; t_owner = 0;
        forever begin
            @(negedge clk);
            cur_fmt = {len, num_stop, par_en, par};
            if (rst) begin
                for (int r = 0; r < N; r++) exp_q[r].delete();
                m_ptr = 0; t_cnt = 0; t_last = 1'b0;
            end else begin
                if (!p_rst && p_grant == '0 && !p_busy) begin
                    exp_g = '0;
                    j_exp = -1;
                    for (int k = 0; k < N; k++) begin
                        if (j_exp < 0 && p_vld[(m_ptr + k) % N]) j_exp = (m_ptr + k) % N;
                    end
                    if (j_exp >= 0) exp_g[j_exp] = 1'b1;
                    chk("arb_grant", 32'(grant), 32'(exp_g));
                    if (j_exp >= 0) t_owner = j_exp;
                end else if (!p_rst && p_grant != '0 && grant != '0) begin
                    chk("grant_hold", 32'(grant), 32'(p_grant));
                end
                if (!p_rst && p_grant != '0 && grant == '0) begin
                    chk("exit_cond", 32'((t_cnt > 0) && (t_last || t_cnt == MB)), 32'd1);
                    m_ptr  = (t_owner + 1) % N;
                    t_cnt  = 0;
                    t_last = 1'b0;
                end
                chk("rdy_only_owner", 32'(req_rdy & ~grant), 32'd0);
                if (tf_ff) chk("full_blocks", {30'd0, req_rdy != '0, tf_we}, 32'd0);
                if (tf_we) begin
                    chk("write_owner", 32'(grant), 32'(1 << t_owner));
                    n_vec++;
                    if (exp_q[t_owner].size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_write: got %0h from req %0d, expected none", tf_di, t_owner);
                    end else begin
                        e = exp_q[t_owner].pop_front();
                        chk("write_data_fmt", {19'd0, cur_fmt, tf_di}, {19'd0, e.fmt, e.data});
                        chk("burst_room", 32'((t_cnt < MB) && !t_last), 32'd1);
                        t_cnt++;
                        t_last = e.last;
                    end
                end
                if (!p_rst && cur_fmt != p_fmt) chk("fmt_change_gated", 32'(ef2), 32'd1);
            end
            ef2 = ef1; ef1 = tf_ef & tx_idle;
            p_fmt = cur_fmt; p_grant = grant; p_busy = busy; p_vld = req_vld; p_rst = rst;
        end
    end

    // ----------------------------------------------------------- stimulus
    initial begin : stim
        int w;
        rst = 1'b1; req_vld = '0; req_last = '0; req_data = '0; req_fmt = '0;
        tf_ff = 1'b0; tf_ef = 1'b1; tx_idle = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {9'd0, tf_we, tf_di, len, num_stop, par_en, par, grant, busy, req_rdy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Same format as reset: three bytes straight through.
        add_msg(0, 5'b00000, 3, 8'hA1);
        apply();
        repeat (8) cycle();
        chk("s1_done", 32'(pending()), 32'd0);

        // Different format with FIFO not empty: hold in DRAIN.
        f_ef = 1'b0;
        add_msg(1, 5'b11011, 2, 8'h30);
        apply();
        repeat (4) cycle();
        chk("s3_drain", {26'd0, busy, grant[1], tf_we, len, par_en, par[0]}, {26'd0, 6'b110000});
        f_ef = 1'b1;
        apply();
        repeat (6) cycle();
        chk("s3_fmt", {27'd0, len, num_stop, par_en, par}, {27'd0, 5'b11011});
        chk("s3_done", 32'(pending()), 32'd0);

        // Randomized traffic.
        gen_en = 1'b1; wh_en = 1'b1; rnd_tf = 1'b1;
        repeat (3000) cycle();
        gen_en = 1'b0; wh_en = 1'b0; rnd_tf = 1'b0;
        f_ff = 1'b0; f_ef = 1'b1; f_idle = 1'b1;
        w = 0;
        while (pending() != 0 && w < 3000) begin
            cycle();
            w++;
        end
        repeat (3) cycle();
        chk("drain_done", 32'(pending()), 32'd0);

        // Reset in the middle of a message.
        add_msg(2, 5'b11011, 10, 8'h80);
        apply();
        w = 0;
        while (!tf_we && w < 50) begin
            cycle();
            w++;
        end
        chk("s6_writing", 32'(tf_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_no_write_in_reset", 32'(tf_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < N; r++) drv_q[r].delete();
        apply();
        @(negedge clk);
        chk("s6_after_reset", {22'd0, grant, busy, len, num_stop, par_en, par, tf_we}, 32'd0);
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_tx_sched
`default_nettype wire
